// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit.
// Contents:
//   - opcode constants (8-bit instruction opcode field)
//   - FSM state enum and opcode class enum
//   - ALU function and branch-type encodings
//   - packed control word produced by ctrl_decode and held by the FSM
package multicycle_control_unit_pkg;

   localparam int OPC_W   = 8;
   localparam int ALUOP_W = 3;

   localparam logic [OPC_W-1:0] OP_LOADI = 8'h00;
   localparam logic [OPC_W-1:0] OP_MOV   = 8'h01;
   localparam logic [OPC_W-1:0] OP_ADD   = 8'h02;
   localparam logic [OPC_W-1:0] OP_SUB   = 8'h03;
   localparam logic [OPC_W-1:0] OP_AND   = 8'h04;
   localparam logic [OPC_W-1:0] OP_OR    = 8'h05;
   localparam logic [OPC_W-1:0] OP_J     = 8'h06;
   localparam logic [OPC_W-1:0] OP_BEQ   = 8'h07;
   localparam logic [OPC_W-1:0] OP_SLL   = 8'h08;
   localparam logic [OPC_W-1:0] OP_SRL   = 8'h09;
   localparam logic [OPC_W-1:0] OP_SRA   = 8'h0A;
   localparam logic [OPC_W-1:0] OP_ROR   = 8'h0B;
   localparam logic [OPC_W-1:0] OP_MULT  = 8'h0C;
   localparam logic [OPC_W-1:0] OP_BNE   = 8'h0D;
   localparam logic [OPC_W-1:0] OP_LWD   = 8'h0E;
   localparam logic [OPC_W-1:0] OP_SWD   = 8'h0F;
   localparam logic [OPC_W-1:0] OP_LWI   = 8'h10;
   localparam logic [OPC_W-1:0] OP_SWI   = 8'h11;

   // ALU functions. Subtraction is ADD with MUX1=0 (negated operand 2);
   // a right logical shift is SHL by a negated amount (MUX1=0).
   localparam logic [ALUOP_W-1:0] ALU_FWD  = 3'b000;
   localparam logic [ALUOP_W-1:0] ALU_ADD  = 3'b001;
   localparam logic [ALUOP_W-1:0] ALU_AND  = 3'b010;
   localparam logic [ALUOP_W-1:0] ALU_OR   = 3'b011;
   localparam logic [ALUOP_W-1:0] ALU_MULT = 3'b100;
   localparam logic [ALUOP_W-1:0] ALU_SHL  = 3'b101;
   localparam logic [ALUOP_W-1:0] ALU_SRA  = 3'b110;
   localparam logic [ALUOP_W-1:0] ALU_ROR  = 3'b111;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_EQ   = 2'b01;
   localparam logic [1:0] BR_NE   = 2'b10;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_e;

   // CLS_NONE marks an undefined opcode.
   typedef enum logic [2:0] {CLS_NONE, CLS_ALU, CLS_BRANCH, CLS_LOAD, CLS_STORE} op_class_e;

   typedef struct packed {
      op_class_e            cls;
      logic                 mux1;
      logic                 mux2;
      logic                 jump;
      logic [1:0]           branch;
      logic [ALUOP_W-1:0]   aluop;
      logic                 reg_write;
   } ctrl_word_t;

endpackage

// File: rtl/multicycle_control_unit_ctrl_decode.sv
// ctrl_decode: purely combinational opcode -> control word mapping.
// Ports:
//   opcode  in  O   opcode field of the instruction
//   cw      out     control word; all-zero (cls = CLS_NONE) for undefined opcodes
module ctrl_decode
   import multicycle_control_unit_pkg::*;
#(
   parameter int O = 8
)
(
   input  logic [O-1:0] opcode,
   output ctrl_word_t   cw
);

   function automatic ctrl_word_t mk(input op_class_e c, input logic m1, input logic m2,
                                     input logic j, input logic [1:0] br,
                                     input logic [ALUOP_W-1:0] op, input logic rw);
      mk = '{c, m1, m2, j, br, op, rw};
   endfunction

   always_comb begin
      cw = '0;
      case (opcode)
         O'(OP_LOADI): cw = mk(CLS_ALU,    1'b1, 1'b1, 1'b0, BR_NONE, ALU_FWD,  1'b0);
         O'(OP_MOV):   cw = mk(CLS_ALU,    1'b1, 1'b0, 1'b0, BR_NONE, ALU_FWD,  1'b0);
         O'(OP_ADD):   cw = mk(CLS_ALU,    1'b1, 1'b0, 1'b0, BR_NONE, ALU_ADD,  1'b0);
         O'(OP_SUB):   cw = mk(CLS_ALU,    1'b0, 1'b0, 1'b0, BR_NONE, ALU_ADD,  1'b0);
         O'(OP_AND):   cw = mk(CLS_ALU,    1'b1, 1'b0, 1'b0, BR_NONE, ALU_AND,  1'b0);
         O'(OP_OR):    cw = mk(CLS_ALU,    1'b1, 1'b0, 1'b0, BR_NONE, ALU_OR,   1'b0);
         O'(OP_J):     cw = mk(CLS_BRANCH, 1'b0, 1'b0, 1'b1, BR_NONE, ALU_FWD,  1'b0);
         O'(OP_BEQ):   cw = mk(CLS_BRANCH, 1'b0, 1'b0, 1'b0, BR_EQ,   ALU_ADD,  1'b0);
         O'(OP_SLL):   cw = mk(CLS_ALU,    1'b1, 1'b1, 1'b0, BR_NONE, ALU_SHL,  1'b0);
         O'(OP_SRL):   cw = mk(CLS_ALU,    1'b0, 1'b1, 1'b0, BR_NONE, ALU_SHL,  1'b0);
         O'(OP_SRA):   cw = mk(CLS_ALU,    1'b1, 1'b1, 1'b0, BR_NONE, ALU_SRA,  1'b0);
         O'(OP_ROR):   cw = mk(CLS_ALU,    1'b1, 1'b1, 1'b0, BR_NONE, ALU_ROR,  1'b0);
         O'(OP_MULT):  cw = mk(CLS_ALU,    1'b1, 1'b0, 1'b0, BR_NONE, ALU_MULT, 1'b0);
         O'(OP_BNE):   cw = mk(CLS_BRANCH, 1'b0, 1'b0, 1'b0, BR_NE,   ALU_ADD,  1'b0);
         O'(OP_LWD):   cw = mk(CLS_LOAD,   1'b1, 1'b0, 1'b0, BR_NONE, ALU_FWD,  1'b1);
         O'(OP_SWD):   cw = mk(CLS_STORE,  1'b1, 1'b0, 1'b0, BR_NONE, ALU_FWD,  1'b0);
         O'(OP_LWI):   cw = mk(CLS_LOAD,   1'b1, 1'b1, 1'b0, BR_NONE, ALU_FWD,  1'b1);
         O'(OP_SWI):   cw = mk(CLS_STORE,  1'b1, 1'b1, 1'b0, BR_NONE, ALU_FWD,  1'b0);
         default:      cw = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer for a
// multicycle datapath.
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   INSTRUCTION, INSTR_VALID   instruction source; INSTR_READY high in FETCH
//   BUSYWAIT                   data memory stall (only looked at in MEM)
//   ZERO                       ALU zero flag (only looked at in EXEC)
//   MUX1, MUX2, JUMP, BRANCH, ALUOP, reg_write   datapath control fields
//   WRITE                      register-file write strobe (WB only)
//   read_mem, write_mem        data memory requests (MEM only)
//   PC_EN, TAKEN               PC advance pulse and target select
//   ILLEGAL                    one-cycle pulse on an undefined opcode
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int I  = 32,
   parameter int O  = 8,
   parameter int AO = 3
)
(
   input  logic          CLK,
   input  logic          RESET,
   input  logic [I-1:0]  INSTRUCTION,
   input  logic          INSTR_VALID,
   output logic          INSTR_READY,
   input  logic          BUSYWAIT,
   input  logic          ZERO,
   output logic          MUX1,
   output logic          MUX2,
   output logic          JUMP,
   output logic [1:0]    BRANCH,
   output logic [AO-1:0] ALUOP,
   output logic          WRITE,
   output logic          reg_write,
   output logic          read_mem,
   output logic          write_mem,
   output logic          PC_EN,
   output logic          TAKEN,
   output logic          ILLEGAL
);

   state_e       state;
   logic [O-1:0] opcode_q;
   logic [O-1:0] dec_opcode;
   ctrl_word_t   dec_cw;
   ctrl_word_t   cw_q;
   logic         pc_en_q;

   // Only the opcode field steers control; operand fields belong to the datapath.
   logic instr_unused;
   assign instr_unused = ^INSTRUCTION[I-O-1:0];

   // In FETCH the decoder looks at the incoming word so an undefined opcode
   // can be flagged in the DECODE cycle itself; afterwards it sees the latch.
   assign dec_opcode = (state == FETCH) ? INSTRUCTION[I-1:I-O] : opcode_q;

   ctrl_decode #(.O(O)) u_ctrl_decode (
      .opcode (dec_opcode),
      .cw     (dec_cw)
   );

   assign MUX1      = cw_q.mux1;
   assign MUX2      = cw_q.mux2;
   assign JUMP      = cw_q.jump;
   assign BRANCH    = cw_q.branch;
   assign ALUOP     = AO'(cw_q.aluop);
   assign reg_write = cw_q.reg_write;

   // A store ends in the MEM cycle where BUSYWAIT drops, and a branch resolves
   // on ZERO in its EXEC cycle; both depend on live inputs of that same cycle.
   assign PC_EN = pc_en_q | ((state == MEM) & write_mem & ~BUSYWAIT);
   assign TAKEN = (state == EXEC) &
                  (cw_q.jump | ((cw_q.branch == BR_EQ) & ZERO) | ((cw_q.branch == BR_NE) & ~ZERO));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= FETCH;
         opcode_q    <= '0;
         cw_q        <= '0;
         INSTR_READY <= 1'b1;
         WRITE       <= 1'b0;
         read_mem    <= 1'b0;
         write_mem   <= 1'b0;
         pc_en_q     <= 1'b0;
         ILLEGAL     <= 1'b0;
      end else begin
         unique case (state)
            FETCH: begin
               if (INSTR_VALID) begin
                  opcode_q    <= INSTRUCTION[I-1:I-O];
                  INSTR_READY <= 1'b0;
                  ILLEGAL     <= (dec_cw.cls == CLS_NONE);
                  pc_en_q     <= (dec_cw.cls == CLS_NONE);
                  state       <= DECODE;
               end
            end
            DECODE: begin
               if (ILLEGAL) begin
                  ILLEGAL     <= 1'b0;
                  pc_en_q     <= 1'b0;
                  INSTR_READY <= 1'b1;
                  state       <= FETCH;
               end else begin
                  cw_q    <= dec_cw;
                  pc_en_q <= (dec_cw.cls == CLS_BRANCH);
                  state   <= EXEC;
               end
            end
            EXEC: begin
               pc_en_q <= 1'b0;
               unique case (cw_q.cls)
                  CLS_BRANCH: begin
                     cw_q        <= '0;
                     INSTR_READY <= 1'b1;
                     state       <= FETCH;
                  end
                  CLS_LOAD: begin
                     read_mem <= 1'b1;
                     state    <= MEM;
                  end
                  CLS_STORE: begin
                     write_mem <= 1'b1;
                     state     <= MEM;
                  end
                  default: begin
                     WRITE   <= 1'b1;
                     pc_en_q <= 1'b1;
                     state   <= WB;
                  end
               endcase
            end
            MEM: begin
               if (!BUSYWAIT) begin
                  read_mem  <= 1'b0;
                  write_mem <= 1'b0;
                  if (cw_q.cls == CLS_LOAD) begin
                     WRITE   <= 1'b1;
                     pc_en_q <= 1'b1;
                     state   <= WB;
                  end else begin
                     cw_q        <= '0;
                     INSTR_READY <= 1'b1;
                     state       <= FETCH;
                  end
               end
            end
            WB: begin
               WRITE       <= 1'b0;
               pc_en_q     <= 1'b0;
               cw_q        <= '0;
               INSTR_READY <= 1'b1;
               state       <= FETCH;
            end
            default: begin
               cw_q        <= '0;
               INSTR_READY <= 1'b1;
               state       <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios followed by random
// instruction streams, each cycle compared against a timeline model built
// from instruction class, stall count and ZERO.
module tb_multicycle_control_unit;

   localparam int I  = 32;
   localparam int O  = 8;
   localparam int AO = 3;

   localparam int K_ALU = 0;
   localparam int K_BR  = 1;
   localparam int K_LD  = 2;
   localparam int K_ST  = 3;
   localparam int K_ILL = 4;

   // {MUX1, MUX2, JUMP, BRANCH[1:0], ALUOP[2:0], reg_write} per defined opcode
   localparam logic [8:0] FIELDS [18] = '{
      9'b1_1_0_00_000_0,  // 00 loadi
      9'b1_0_0_00_000_0,  // 01 mov
      9'b1_0_0_00_001_0,  // 02 add
      9'b0_0_0_00_001_0,  // 03 sub
      9'b1_0_0_00_010_0,  // 04 and
      9'b1_0_0_00_011_0,  // 05 or
      9'b0_0_1_00_000_0,  // 06 j
      9'b0_0_0_01_001_0,  // 07 beq
      9'b1_1_0_00_101_0,  // 08 sll
      9'b0_1_0_00_101_0,  // 09 srl
      9'b1_1_0_00_110_0,  // 0A sra
      9'b1_1_0_00_111_0,  // 0B ror
      9'b1_0_0_00_100_0,  // 0C mult
      9'b0_0_0_10_001_0,  // 0D bne
      9'b1_0_0_00_000_1,  // 0E lwd
      9'b1_0_0_00_000_0,  // 0F swd
      9'b1_1_0_00_000_1,  // 10 lwi
      9'b1_1_0_00_000_0   // 11 swi
   };

   logic          CLK = 1'b0;
   logic          RESET;
   logic [I-1:0]  INSTRUCTION;
   logic          INSTR_VALID;
   logic          INSTR_READY;
   logic          BUSYWAIT;
   logic          ZERO;
   logic          MUX1, MUX2, JUMP;
   logic [1:0]    BRANCH;
   logic [AO-1:0] ALUOP;
   logic          WRITE, reg_write, read_mem, write_mem, PC_EN, TAKEN, ILLEGAL;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   multicycle_control_unit #(.I(I), .O(O), .AO(AO)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .INSTRUCTION (INSTRUCTION),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY),
      .BUSYWAIT    (BUSYWAIT),
      .ZERO        (ZERO),
      .MUX1        (MUX1),
      .MUX2        (MUX2),
      .JUMP        (JUMP),
      .BRANCH      (BRANCH),
      .ALUOP       (ALUOP),
      .WRITE       (WRITE),
      .reg_write   (reg_write),
      .read_mem    (read_mem),
      .write_mem   (write_mem),
      .PC_EN       (PC_EN),
      .TAKEN       (TAKEN),
      .ILLEGAL     (ILLEGAL)
   );

   always #5 CLK = ~CLK;

   wire [15:0] outs = {INSTR_READY, MUX1, MUX2, JUMP, BRANCH, ALUOP,
                       WRITE, reg_write, read_mem, write_mem, PC_EN, TAKEN, ILLEGAL};

   function automatic int op_kind(input logic [7:0] op);
      if (op > 8'h11) return K_ILL;
      if (op == 8'h06 || op == 8'h07 || op == 8'h0D) return K_BR;
      if (op == 8'h0E || op == 8'h10) return K_LD;
      if (op == 8'h0F || op == 8'h11) return K_ST;
      return K_ALU;
   endfunction

   function automatic int latency(input int kind, input int s);
      case (kind)
         K_BR:    return 2;
         K_ST:    return 3 + s;
         K_LD:    return 4 + s;
         K_ILL:   return 1;
         default: return 3;
      endcase
   endfunction

   // Expected outputs k cycles after the handshake cycle (k = 0).
   function automatic logic [15:0] expect_out(input logic [7:0] op, input int kind, input int k,
                                              input int s, input logic z, input int lat);
      logic [8:0] f;
      logic rdy, wr, rm, wm, pe, tk, il;
      f   = (kind != K_ILL && k >= 2) ? FIELDS[int'(op)] : 9'h000;
      rdy = (k == 0);
      wr  = (kind == K_ALU || kind == K_LD) && k == lat;
      rm  = kind == K_LD && k >= 3 && k <= 3 + s;
      wm  = kind == K_ST && k >= 3 && k <= 3 + s;
      pe  = k > 0 && k == lat;
      tk  = kind == K_BR && k == 2 &&
            (op == 8'h06 || (op == 8'h07 && z) || (op == 8'h0D && !z));
      il  = kind == K_ILL && k == 1;
      return {rdy, f[8:1], wr, f[0], rm, wm, pe, tk, il};
   endfunction

   task automatic check(input string tag, input logic [15:0] exp);
      #1;
      checks++;
      assert (outs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h required %h", tag, outs, exp);
      end
   endtask

   task automatic drive_noise();
      INSTRUCTION = $urandom;
      BUSYWAIT    = 1'($urandom);
      ZERO        = 1'($urandom);
   endtask

   // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH cycle.
   task automatic run_instr(input logic [7:0] op, input int s, input int idle, input int zf);
      int   kind;
      int   lat;
      logic z;
      kind = op_kind(op);
      lat  = latency(kind, s);
      z    = 1'b0;
      for (int c = 0; c < idle; c++) begin
         drive_noise();
         INSTR_VALID = 1'b0;
         check($sformatf("idle op%02h c%0d", op, c), 16'h8000);
         @(posedge CLK); #1;
      end
      drive_noise();
      INSTRUCTION = {op, 24'($urandom)};
      INSTR_VALID = 1'b1;
      check($sformatf("op%02h hs", op), expect_out(op, kind, 0, s, z, lat));
      @(posedge CLK); #1;
      for (int k = 1; k <= lat; k++) begin
         drive_noise();
         INSTR_VALID = 1'($urandom);
         if ((kind == K_LD || kind == K_ST) && k >= 3 && k <= 3 + s) BUSYWAIT = (k < 3 + s);
         if (k == 2 && zf >= 0) ZERO = 1'(zf);
         if (k == 2) z = ZERO;
         check($sformatf("op%02h s%0d k%0d", op, s, k), expect_out(op, kind, k, s, z, lat));
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      RESET       = 1'b1;
      INSTRUCTION = '0;
      INSTR_VALID = 1'b0;
      BUSYWAIT    = 1'b0;
      ZERO        = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("reset state", 16'h8000);
      RESET = 1'b0;

      run_instr(8'h02, 0, 10, -1);   // long idle, then add
      run_instr(8'h0E, 4, 0, -1);    // lwd with four stall cycles
      run_instr(8'h07, 0, 1, 1);     // beq taken
      run_instr(8'h0D, 0, 0, 1);     // bne not taken
      run_instr(8'h0D, 0, 0, 0);     // bne taken
      run_instr(8'h07, 0, 0, 0);     // beq not taken
      run_instr(8'h06, 0, 0, -1);    // jump
      run_instr(8'h2A, 0, 2, -1);    // undefined opcode
      run_instr(8'hFF, 0, 0, -1);    // undefined opcode, top of range
      run_instr(8'h11, 0, 0, -1);    // swi without stall
      run_instr(8'h0F, 3, 0, -1);    // swd with stall
      run_instr(8'h10, 0, 0, -1);    // lwi without stall
      run_instr(8'h03, 0, 0, -1);    // sub

      // reset while a store is stalled in MEM
      INSTRUCTION = {8'h0F, 24'h0};
      INSTR_VALID = 1'b1;
      BUSYWAIT    = 1'b1;
      ZERO        = 1'b0;
      check("swd-rst hs", expect_out(8'h0F, K_ST, 0, 6, 1'b0, 9));
      @(posedge CLK); #1;
      INSTR_VALID = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("swd-rst k%0d", k), expect_out(8'h0F, K_ST, k, 6, 1'b0, 9));
         if (k == 4) RESET = 1'b1;
         @(posedge CLK); #1;
      end
      check("rst drops write_mem", 16'h8000);
      RESET = 1'b0;
      @(posedge CLK); #1;
      check("rst back in fetch", 16'h8000);
      @(posedge CLK); #1;

      for (int n = 0; n < 60; n++) begin
         logic [7:0] op;
         if ($urandom_range(0, 9) == 0) op = 8'($urandom_range(8'h12, 8'hFF));
         else                           op = 8'($urandom_range(0, 17));
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 2), -1);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter I, default 32, instruction width.
REQ-002 Parameter O, default 8, opcode width; opcode = INSTRUCTION[I-1:I-O].
REQ-003 Parameter AO, default 3, ALUOP width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 CLK  in  1  rising-edge clock.
REQ-006 RESET  in  1  synchronous active-high reset.
REQ-007 INSTRUCTION  in  I  instruction word, sampled only on FETCH handshake.
REQ-008 INSTR_VALID  in  1  instruction source has a word.
REQ-009 INSTR_READY  out  1  block accepts a word (high only in FETCH).
REQ-010 BUSYWAIT  in  1  data memory stall.
REQ-011 ZERO  in  1  ALU zero flag, sampled in EXEC.
REQ-012 MUX1, MUX2, JUMP  out  1 each  datapath selects, held from DECODE exit until instruction end.
REQ-013 BRANCH  out  2  01 beq, 10 bne, 00 none; ALUOP  out  AO  ALU function.
REQ-014 WRITE  out  1  register-file write strobe; reg_write  out  1  writeback source (0 ALU, 1 memory).
REQ-015 read_mem, write_mem  out  1 each  data memory requests.
REQ-016 PC_EN  out  1  one-cycle PC advance pulse; TAKEN  out  1  with PC_EN, selects jump/branch target.
REQ-017 ILLEGAL  out  1  one-cycle pulse on undefined opcode.

Function
REQ-018 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB.
REQ-019 FETCH: INSTR_READY=1; on INSTR_VALID=1 latch INSTRUCTION, go DECODE; else stay.
REQ-020 DECODE (1 cycle): register the control word per opcode: 0x00 loadi, 0x01 mov, 0x02 add, 0x03 sub, 0x04 and, 0x05 or, 0x06 j, 0x07 beq, 0x08 sll, 0x09 srl, 0x0A sra, 0x0B ror, 0x0C mult, 0x0D bne, 0x0E lwd, 0x0F swd, 0x10 lwi, 0x11 swi; go EXEC.
REQ-021 Every field SHALL be defined for every opcode; fields not used by an instruction are 0 (no latching of stale values).
REQ-022 EXEC (1 cycle): ALU/shift/mult ops go WB; loads/stores go MEM; j/beq/bne go FETCH asserting PC_EN.
REQ-023 Branch resolution in EXEC: TAKEN = JUMP | (beq & ZERO) | (bne & ~ZERO).
REQ-024 MEM: read_mem or write_mem held high while BUSYWAIT=1; leave on first cycle with BUSYWAIT=0: load to WB, store to FETCH with PC_EN.
REQ-025 WB (1 cycle): WRITE=1, PC_EN=1, TAKEN=0, then FETCH.
REQ-026 WRITE SHALL be high only in WB; read_mem/write_mem only in MEM; PC_EN only in the final state-cycle of an instruction.
REQ-027 Latency from FETCH handshake to PC_EN: ALU 3 cycles, branch/jump 2, store 3+stall, load 4+stall.
REQ-028 Undefined opcode (>0x11 for O=8): DECODE pulses ILLEGAL, clears all control fields, goes FETCH with PC_EN=1, TAKEN=0, no write or memory access.
REQ-029 BUSYWAIT outside MEM SHALL be ignored; INSTR_VALID outside FETCH SHALL be ignored.
REQ-030 RESET asserted in any state SHALL win over every transition, including mid-MEM stall.

Reset
REQ-031 On RESET: state=FETCH next cycle; all outputs 0 except INSTR_READY=1; latched instruction cleared to 0.
REQ-032 An in-flight memory request SHALL be dropped on reset (read_mem/write_mem 0 the cycle after RESET is sampled).

Structure
REQ-033 Opcode constants, state enum, and packed control-word struct SHALL live in a shared package.
REQ-034 Opcode-to-control-word mapping SHALL be a combinational sub-module ctrl_decode, instantiated once; FSM and registers in the top.

Verification
REQ-035 add (0x02): handshake at t0 -> PC_EN and WRITE at t0+3, ALUOP=001, MUX1=1, MUX2=0, reg_write=0.
REQ-036 lwd (0x0E) with BUSYWAIT high 4 cycles -> read_mem high 5 cycles, WRITE with reg_write=1 one cycle later, PC_EN at t0+8.
REQ-037 beq (0x07) ZERO=1 -> PC_EN=1, TAKEN=1 at t0+2, WRITE never high; bne (0x0D) ZERO=1 -> TAKEN=0.
REQ-038 opcode 0x2A -> ILLEGAL pulse at t0+1, PC_EN at t0+1, no WRITE/read_mem/write_mem.
REQ-039 RESET during swd (0x0F) MEM stall -> write_mem 0 next cycle, state FETCH, INSTR_READY=1.
REQ-040 INSTR_VALID=0 for 10 cycles then 1 -> INSTR_READY held, no outputs toggle until handshake.
